ov7670_pixel_capture: RTL and testbench
=======================================

// Module: ov7670_pixel_capture
// PURPOSE
// Parametrised camera pixel-capture engine for the OV7670 path, clocked by camera PCLK.
// Qualifies frames with VSYNC/HREF and assembles BYTES_PER_PIX bytes into one pixel word.
// Tracks row/col, checks line/frame geometry, and hands pixels downstream on valid/ready.
// Supports single-shot and continuous capture, with optional frame skipping.
// Sits between the camera data pins and the frame-buffer writer.
// PARAMETERS
// DATA_W         8    camera bus width
// BYTES_PER_PIX  2    bytes per pixel (1..4); RGB565/YUV422 = 2
// H_ACTIVE       640  pixels per line
// V_ACTIVE       480  lines per frame
// SKIP_W         4    width of frame_skip input
// PORTS
// clk            in   1                   camera PCLK; all logic on posedge
// reset          in   1                   synchronous, active-low
// cap_en         in   1                   arm capture; sampled every cycle
// continuous     in   1                   1 = keep capturing; 0 = one frame then DONE
// frame_skip     in   SKIP_W              frames discarded between captured frames
// vsync          in   1                   camera VSYNC, active-high blanking
// href           in   1                   camera HREF, high during active bytes
// cam_data       in   DATA_W              camera data byte
// pix_data       out  DATA_W*BYTES_PER_PIX assembled pixel; first byte in MSBs
// pix_valid      out  1                   pixel available
// pix_ready      in   1                   downstream accepts when valid&ready
// pix_col        out  $clog2(H_ACTIVE)    column of pix_data
// pix_row        out  $clog2(V_ACTIVE)    row of pix_data
// frame_start    out  1                   1-cycle pulse at first active line of captured frame
// frame_done     out  1                   1-cycle pulse at end of captured frame
// busy           out  1                   state != IDLE
// err_line       out  1                   sticky: line length != H_ACTIVE
// err_frame      out  1                   sticky: line count != V_ACTIVE
// err_overflow   out  1                   sticky: pixel dropped
// BEHAVIOUR
// - Reset (reset==0 at posedge clk): state=IDLE; counters=0; all outputs 0.
//   Sticky error flags clear only on reset.
// - Edge detect: registered copy of vsync; vs_rise/vs_fall are computed against it.
// - States:
//   - IDLE: cap_en=1 -> SYNC; skip_cnt=frame_skip.
//   - SYNC: wait for vs_fall. On vs_fall, skip_cnt!=0 -> decrement, stay in SYNC;
//     else -> ACTIVE with row=0, col=0, byte_ph=0.
//   - ACTIVE: capture bytes. On vs_rise:
//     - frame_done pulses and err_frame is set if row!=V_ACTIVE.
//     - Then ->SYNC (skip_cnt reloaded) if continuous&cap_en, else ->DONE.
//   - DONE: cap_en=0 -> IDLE. Deassert-then-assert rearms.
// - cap_en=0 in SYNC -> IDLE immediately.
// - cap_en=0 in ACTIVE: finish the current frame, then go to DONE.
// - Byte assembly in ACTIVE, per cycle with href=1:
//   - Shift cam_data into the assembly register and increment byte_ph.
//   - At byte_ph==BYTES_PER_PIX-1, the pixel is complete; byte_ph wraps to 0.
// - frame_start pulses with the first href=1 byte of row 0.
// - Output register: a completed pixel loads pix_data/pix_col/pix_row and sets pix_valid
//   on the next cycle (latency 1 cycle after the last byte sampled).
//   - If pix_valid=1 and pix_ready=0 when a new pixel completes, the new pixel is dropped,
//     err_overflow is set, and the held pixel stays unchanged.
//   - If pix_ready=1 in the same cycle, the new pixel replaces it (no drop).
//   - pix_valid clears on valid&ready with no new pixel.
// - Line end (href 1->0 in ACTIVE):
//   - err_line is set if col!=H_ACTIVE or byte_ph!=0.
//   - col=0, byte_ph=0, row++ (row saturates at V_ACTIVE).
// - col increments per completed pixel. At H_ACTIVE it stops incrementing; excess pixels
//   are dropped and err_line is set at line end.
// - href=1 outside ACTIVE is ignored.
// - vs_rise while href=1: the line is abandoned and the frame-end rules apply.
// - Reset mid-frame: immediately IDLE. The next capture needs a fresh vs_fall, so a
//   partial frame is never emitted.
// STRUCTURE
// - ov7670_pkg: capture_state_t enum {IDLE,SYNC,ACTIVE,DONE}; VGA/QVGA H/V constants;
//   BYTES_RGB565=2.
// - One sub-module, ov7670_pixel_assembler: byte shift register plus byte_ph.
//   Outputs a pixel_done strobe; params DATA_W, BYTES_PER_PIX.
// - FSM, counters, checks and output register live in the top.
// TESTING (bench: H_ACTIVE=4, V_ACTIVE=3, BYTES_PER_PIX=2, pix_ready=1 unless noted)
// - Single shot: cap_en=1, continuous=0, frame_skip=0; 3 lines x 8 bytes 0x01..0x18
//   -> 12 pixels, first 0x0102 at (0,0), last 0x1718 at (col 3,row 2);
//   frame_start and frame_done once each; no errors; state DONE.
// - Back-pressure: pix_ready=0 across pixels 2-3 -> pixel 1 (0x0102) held,
//   pixels 2-3 dropped, err_overflow=1; resume -> pixel 4 (0x0708) accepted.
// - Short line: line 1 has 6 bytes -> err_line=1, row still 3 at vsync, err_frame=0.
//   Odd 7-byte line -> err_line=1.
// - Frame skip: frame_skip=2, continuous=1 -> frames 0,1 ignored; frame 2 captured;
//   next captured frame is 5.
// - Reset mid-frame: reset=0 for 1 cycle during row 1 -> all outputs 0, state IDLE;
//   no pixel until after the next vs_fall.
// - cap_en dropped in ACTIVE with continuous=1 -> current frame completes, frame_done,
//   DONE; no further pixels.

Source files
------------

// File: rtl/ov7670_pkg.sv
// Shared types and constants for the OV7670 capture path.
package ov7670_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2,
        DONE   = 2'd3
    } capture_state_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SYNC   = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam int VGA_H_ACTIVE  = 640;
    localparam int VGA_V_ACTIVE  = 480;
    localparam int QVGA_H_ACTIVE = 320;
    localparam int QVGA_V_ACTIVE = 240;
    localparam int BYTES_RGB565  = 2;

    // Byte-phase counter width; never narrower than one bit.
    function automatic int ph_width(input int bytes_per_pix);
        return (bytes_per_pix > 1) ? $clog2(bytes_per_pix) : 1;
    endfunction

endpackage

// File: rtl/ov7670_pixel_assembler.sv
// Shifts camera bytes into a pixel word; first byte ends up in the MSBs.
module ov7670_pixel_assembler
    import ov7670_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int BYTES_PER_PIX = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              clear,
    input  logic                              shift_en,
    input  logic [DATA_W-1:0]                 cam_data,
    output logic [DATA_W*BYTES_PER_PIX-1:0]   pixel,
    output logic                              pixel_done,
    output logic [ph_width(BYTES_PER_PIX)-1:0] byte_ph
);
    localparam int PIX_W = DATA_W * BYTES_PER_PIX;
    localparam int PH_W  = ph_width(BYTES_PER_PIX);
    localparam logic [PH_W-1:0] LAST_PH = PH_W'(BYTES_PER_PIX - 1);

    logic [PIX_W-1:0] shift_q;

    // The completed word includes the byte being sampled this cycle.
    assign pixel      = (shift_q << DATA_W) | PIX_W'(cam_data);
    assign pixel_done = shift_en && (byte_ph == LAST_PH);

    always_ff @(posedge clk) begin
        if (!reset) begin
            shift_q <= '0;
            byte_ph <= '0;
        end else if (clear) begin
            byte_ph <= '0;
        end else if (shift_en) begin
            shift_q <= pixel;
            byte_ph <= pixel_done ? '0 : byte_ph + 1'b1;
        end
    end

endmodule

// File: rtl/ov7670_pixel_capture.sv
// OV7670 frame qualification, pixel assembly, geometry checks and valid/ready output stage.
module ov7670_pixel_capture
    import ov7670_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int BYTES_PER_PIX = 2,
    parameter int H_ACTIVE      = 640,
    parameter int V_ACTIVE      = 480,
    parameter int SKIP_W        = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            cap_en,
    input  logic                            continuous,
    input  logic [SKIP_W-1:0]               frame_skip,
    input  logic                            vsync,
    input  logic                            href,
    input  logic [DATA_W-1:0]               cam_data,
    output logic [DATA_W*BYTES_PER_PIX-1:0] pix_data,
    output logic                            pix_valid,
    input  logic                            pix_ready,
    output logic [$clog2(H_ACTIVE)-1:0]     pix_col,
    output logic [$clog2(V_ACTIVE)-1:0]     pix_row,
    output logic                            frame_start,
    output logic                            frame_done,
    output logic                            busy,
    output logic                            err_line,
    output logic                            err_frame,
    output logic                            err_overflow,
    output logic [1:0]                      state_dbg
);
    // pix_valid/pix_ready: a pixel transfers on every posedge where both are high;
    // while pix_valid is high and pix_ready low, pix_data/col/row hold steady.
    localparam int PIX_W  = DATA_W * BYTES_PER_PIX;
    localparam int COL_W  = $clog2(H_ACTIVE);
    localparam int ROW_W  = $clog2(V_ACTIVE);
    localparam int CCNT_W = $clog2(H_ACTIVE + 1);
    localparam int RCNT_W = $clog2(V_ACTIVE + 1);
    localparam int PH_W   = ph_width(BYTES_PER_PIX);
    localparam logic [CCNT_W-1:0] H_MAX = CCNT_W'(H_ACTIVE);
    localparam logic [RCNT_W-1:0] V_MAX = RCNT_W'(V_ACTIVE);

    logic [1:0]        state;
    logic [SKIP_W-1:0] skip_cnt;
    logic [CCNT_W-1:0] col_cnt;
    logic [RCNT_W-1:0] row_cnt;
    logic              vsync_q, href_q;
    logic              line_excess, started;
    logic              vs_rise, vs_fall, line_end, capture, new_pix;
    logic              asm_done;
    logic [PIX_W-1:0]  asm_pixel;
    logic [PH_W-1:0]   byte_ph;

    assign vs_rise  = vsync && !vsync_q;
    assign vs_fall  = !vsync && vsync_q;
    assign capture  = (state == ST_ACTIVE) && href && !vs_rise;
    assign line_end = (state == ST_ACTIVE) && href_q && !href && !vs_rise;
    // Pixels past the line or frame geometry are discarded, not forwarded.
    assign new_pix  = asm_done && (col_cnt < H_MAX) && (row_cnt < V_MAX);

    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

    ov7670_pixel_assembler #(
        .DATA_W        (DATA_W),
        .BYTES_PER_PIX (BYTES_PER_PIX)
    ) u_assembler (
        .clk        (clk),
        .reset      (reset),
        .clear      ((state != ST_ACTIVE) || line_end),
        .shift_en   (capture),
        .cam_data   (cam_data),
        .pixel      (asm_pixel),
        .pixel_done (asm_done),
        .byte_ph    (byte_ph)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            skip_cnt    <= '0;
            col_cnt     <= '0;
            row_cnt     <= '0;
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            line_excess <= 1'b0;
            started     <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            err_line    <= 1'b0;
            err_frame   <= 1'b0;
        end else begin
            vsync_q     <= vsync;
            href_q      <= href;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cap_en) begin
                        state    <= ST_SYNC;
                        skip_cnt <= frame_skip;
                    end
                end
                ST_SYNC: begin
                    if (!cap_en) begin
                        state <= ST_IDLE;
                    end else if (vs_fall) begin
                        if (skip_cnt != '0) begin
                            skip_cnt <= skip_cnt - 1'b1;
                        end else begin
                            state       <= ST_ACTIVE;
                            col_cnt     <= '0;
                            row_cnt     <= '0;
                            line_excess <= 1'b0;
                            started     <= 1'b0;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (vs_rise) begin
                        // An open line is abandoned; only frame-level checks apply.
                        frame_done <= 1'b1;
                        if (row_cnt != V_MAX) err_frame <= 1'b1;
                        if (continuous && cap_en) begin
                            state    <= ST_SYNC;
                            skip_cnt <= frame_skip;
                        end else begin
                            state <= ST_DONE;
                        end
                    end else begin
                        if (line_end) begin
                            if (col_cnt != H_MAX || byte_ph != '0 || line_excess) err_line <= 1'b1;
                            col_cnt     <= '0;
                            line_excess <= 1'b0;
                            if (row_cnt != V_MAX) row_cnt <= row_cnt + 1'b1;
                        end
                        if (asm_done) begin
                            if (col_cnt < H_MAX) col_cnt <= col_cnt + 1'b1;
                            else                 line_excess <= 1'b1;
                        end
                        if (capture && row_cnt == '0 && !started) begin
                            frame_start <= 1'b1;
                            started     <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (!cap_en) state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pix_data     <= '0;
            pix_col      <= '0;
            pix_row      <= '0;
            pix_valid    <= 1'b0;
            err_overflow <= 1'b0;
        end else if (new_pix) begin
            if (!pix_valid || pix_ready) begin
                pix_data  <= asm_pixel;
                pix_col   <= col_cnt[COL_W-1:0];
                pix_row   <= row_cnt[ROW_W-1:0];
                pix_valid <= 1'b1;
            end else begin
                err_overflow <= 1'b1;
            end
        end else if (pix_valid && pix_ready) begin
            pix_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ov7670_pixel_capture.sv
// Self-checking bench for ov7670_pixel_capture on a 4x3, 2-byte-per-pixel geometry.
module tb_ov7670_pixel_capture;
    import ov7670_pkg::*;

    localparam int H   = 4;
    localparam int V   = 3;
    localparam int BPP = 2;
    localparam int DW  = 8;
    localparam int PW  = DW * BPP;
    localparam int EW  = PW + 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cap_en = 1'b0;
    logic          continuous = 1'b0;
    logic [3:0]    frame_skip = '0;
    logic          vsync = 1'b0;
    logic          href = 1'b0;
    logic [DW-1:0] cam_data = '0;
    logic          pix_ready = 1'b1;
    logic [PW-1:0] pix_data;
    logic          pix_valid;
    logic [1:0]    pix_col;
    logic [1:0]    pix_row;
    logic          frame_start, frame_done, busy;
    logic          err_line, err_frame, err_overflow;
    logic [1:0]    state_dbg;

    int checks = 0;
    int passes = 0;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] got_q[$];
    int            got_rd = 0;
    int            fs_cnt = 0;
    int            fd_cnt = 0;
    logic [1:0]    state_at_done = 2'd0;

    logic [DW-1:0] fb[0:3][0:15];
    int            flen[0:3];
    int            nlines;
    logic          m_err_line, m_err_frame, m_err_ovf;

    ov7670_pixel_capture #(
        .DATA_W(DW), .BYTES_PER_PIX(BPP), .H_ACTIVE(H), .V_ACTIVE(V), .SKIP_W(4)
    ) dut (
        .clk(clk), .reset(reset), .cap_en(cap_en), .continuous(continuous),
        .frame_skip(frame_skip), .vsync(vsync), .href(href), .cam_data(cam_data),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_col(pix_col), .pix_row(pix_row), .frame_start(frame_start),
        .frame_done(frame_done), .busy(busy), .err_line(err_line),
        .err_frame(err_frame), .err_overflow(err_overflow), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Monitor: mid-cycle sample of transfers and pulses.
    always @(negedge clk) begin
        if (pix_valid && pix_ready) got_q.push_back({pix_data, pix_col, pix_row});
        if (frame_start) fs_cnt++;
        if (frame_done) begin
            fd_cnt++;
            state_at_done = state_dbg;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        href = 1'b0;
        cycles(2);
        reset = 1'b1;
        m_err_line = 1'b0;
        m_err_frame = 1'b0;
        m_err_ovf = 1'b0;
        exp_q.delete();
        tick();
        got_rd = got_q.size();
    endtask

    task automatic fill_frame(input int l0, input int l1, input int l2, input int nl,
                              input bit counting);
        int idx = 0;
        nlines = nl;
        flen[0] = l0;
        flen[1] = l1;
        flen[2] = l2;
        for (int r = 0; r < nl; r++)
            for (int k = 0; k < flen[r]; k++) begin
                fb[r][k] = counting ? DW'(idx + 1) : DW'($urandom_range(0, 255));
                idx++;
            end
    endtask

    task automatic drive_line(input int r, input int from, input int to);
        for (int k = from; k < to; k++) begin
            href = 1'b1;
            cam_data = fb[r][k];
            tick();
        end
    endtask

    task automatic line_gap();
        href = 1'b0;
        cam_data = '0;
        cycles(3);
    endtask

    task automatic frame_begin();
        vsync = 1'b1;
        cycles(3);
        vsync = 1'b0;
        cycles(2);
    endtask

    task automatic frame_end();
        vsync = 1'b1;
        cycles(3);
    endtask

    task automatic drive_frame();
        frame_begin();
        for (int r = 0; r < nlines; r++) begin
            drive_line(r, 0, flen[r]);
            line_gap();
        end
        frame_end();
    endtask

    // Reference: pixel k of line r is bytes k*BPP.. joined MSB-first at (col k, row r);
    // only the first H pixels of the first V lines exist; pixels numbered drop_lo..drop_hi
    // (in frame order) are expected lost to back-pressure.
    function automatic void model_frame(input int drop_lo, input int drop_hi);
        int n = 0;
        logic [PW-1:0] px;
        for (int r = 0; r < nlines; r++) begin
            if (flen[r] != H * BPP) m_err_line = 1'b1;
            for (int k = 0; k < flen[r] / BPP; k++) begin
                if (k < H) begin
                    px = '0;
                    for (int b = 0; b < BPP; b++) px = (px << DW) | PW'(fb[r][k * BPP + b]);
                    if (r < V && (n < drop_lo || n > drop_hi))
                        exp_q.push_back({px, 2'(k), 2'(r)});
                    n++;
                end
            end
        end
        if (nlines != V) m_err_frame = 1'b1;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        cycles(3);
        checks++;
        if ({pix_data, pix_valid, pix_col, pix_row} !== '0)
            $display("FAIL reset_pix: got data=%h valid=%b col=%0d row=%0d, expected all 0",
                     pix_data, pix_valid, pix_col, pix_row);
        else passes++;
        checks++;
        if ({frame_start, frame_done, busy, err_line, err_frame, err_overflow} !== 6'b0)
            $display("FAIL reset_flags: got %b, expected 000000",
                     {frame_start, frame_done, busy, err_line, err_frame, err_overflow});
        else passes++;
        checks++;
        if (state_dbg !== IDLE) $display("FAIL reset_state: got %0d, expected %0d", state_dbg, IDLE);
        else passes++;
        reset = 1'b1;
        tick();
        got_rd = got_q.size();
    endtask

    task automatic test_single_shot();
        int fs0, fd0;
        logic [EW-1:0] obs;
        cap_en = 1'b1;
        continuous = 1'b0;
        frame_skip = '0;
        do_reset();
        fs0 = fs_cnt;
        fd0 = fd_cnt;
        fill_frame(8, 8, 8, 3, 1'b1);
        model_frame(1, 0);
        drive_frame();
        checks++;
        obs = (got_rd < got_q.size()) ? got_q[got_rd] : 'x;
        if (obs !== {16'h0102, 2'd0, 2'd0}) $display("FAIL single_first: got %h, expected %h", obs, {16'h0102, 2'd0, 2'd0});
        else passes++;
        checks++;
        obs = (got_q.size() > 0) ? got_q[got_q.size() - 1] : 'x;
        if (obs !== {16'h1718, 2'd3, 2'd2}) $display("FAIL single_last: got %h, expected %h", obs, {16'h1718, 2'd3, 2'd2});
        else passes++;
        checks++;
        if (got_q.size() - got_rd != exp_q.size())
            $display("FAIL single_count: got %0d, expected %0d", got_q.size() - got_rd, exp_q.size());
        else passes++;
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            obs = (got_rd + i < got_q.size()) ? got_q[got_rd + i] : 'x;
            if (obs !== exp_q[i]) $display("FAIL single_pix[%0d]: got %h, expected %h", i, obs, exp_q[i]);
            else passes++;
        end
        checks++;
        if (fs_cnt - fs0 != 1 || fd_cnt - fd0 != 1)
            $display("FAIL single_pulses: got start=%0d done=%0d, expected 1 1", fs_cnt - fs0, fd_cnt - fd0);
        else passes++;
        checks++;
        if ({err_line, err_frame, err_overflow} !== 3'b000)
            $display("FAIL single_errors: got %b, expected 000", {err_line, err_frame, err_overflow});
        else passes++;
        checks++;
        if (state_dbg !== DONE) $display("FAIL single_state: got %0d, expected %0d", state_dbg, DONE);
        else passes++;
    endtask

    task automatic test_back_pressure();
        logic [EW-1:0] obs;
        cap_en = 1'b1;
        continuous = 1'b0;
        do_reset();
        fill_frame(8, 8, 8, 3, 1'b1);
        model_frame(1, 2);
        m_err_ovf = 1'b1;
        frame_begin();
        pix_ready = 1'b0;
        drive_line(0, 0, 6);
        pix_ready = 1'b1;
        drive_line(0, 6, 8);
        line_gap();
        for (int r = 1; r < nlines; r++) begin
            drive_line(r, 0, flen[r]);
            line_gap();
        end
        frame_end();
        checks++;
        obs = (got_rd + 1 < got_q.size()) ? got_q[got_rd + 1] : 'x;
        if (obs !== {16'h0708, 2'd3, 2'd0}) $display("FAIL bp_resume: got %h, expected %h", obs, {16'h0708, 2'd3, 2'd0});
        else passes++;
        checks++;
        if (got_q.size() - got_rd != exp_q.size())
            $display("FAIL bp_count: got %0d, expected %0d", got_q.size() - got_rd, exp_q.size());
        else passes++;
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            obs = (got_rd + i < got_q.size()) ? got_q[got_rd + i] : 'x;
            if (obs !== exp_q[i]) $display("FAIL bp_pix[%0d]: got %h, expected %h", i, obs, exp_q[i]);
            else passes++;
        end
        checks++;
        if ({err_line, err_frame, err_overflow} !== {m_err_line, m_err_frame, m_err_ovf})
            $display("FAIL bp_errors: got %b, expected %b", {err_line, err_frame, err_overflow},
                     {m_err_line, m_err_frame, m_err_ovf});
        else passes++;
    endtask

    task automatic test_short_line();
        int lens[3][3] = '{'{8, 6, 8}, '{8, 7, 8}, '{8, 8, 0}};
        int nls[3] = '{3, 3, 2};
        logic [EW-1:0] obs;
        cap_en = 1'b1;
        continuous = 1'b0;
        for (int t = 0; t < 3; t++) begin
            do_reset();
            fill_frame(lens[t][0], lens[t][1], lens[t][2], nls[t], 1'b0);
            model_frame(1, 0);
            drive_frame();
            checks++;
            if (got_q.size() - got_rd != exp_q.size())
                $display("FAIL short%0d_count: got %0d, expected %0d", t, got_q.size() - got_rd, exp_q.size());
            else passes++;
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                obs = (got_rd + i < got_q.size()) ? got_q[got_rd + i] : 'x;
                if (obs !== exp_q[i]) $display("FAIL short%0d_pix[%0d]: got %h, expected %h", t, i, obs, exp_q[i]);
                else passes++;
            end
            checks++;
            if ({err_line, err_frame, err_overflow} !== {m_err_line, m_err_frame, 1'b0})
                $display("FAIL short%0d_errors: got %b, expected %b", t, {err_line, err_frame, err_overflow},
                         {m_err_line, m_err_frame, 1'b0});
            else passes++;
        end
    endtask

    task automatic test_frame_skip();
        int fs0, fd0;
        logic [EW-1:0] obs;
        cap_en = 1'b1;
        continuous = 1'b1;
        frame_skip = 4'd2;
        do_reset();
        fs0 = fs_cnt;
        fd0 = fd_cnt;
        for (int f = 0; f < 6; f++) begin
            fill_frame(8, 8, 8, 3, 1'b0);
            if (f % 3 == 2) model_frame(1, 0);
            drive_frame();
        end
        checks++;
        if (got_q.size() - got_rd != exp_q.size())
            $display("FAIL skip_count: got %0d, expected %0d", got_q.size() - got_rd, exp_q.size());
        else passes++;
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            obs = (got_rd + i < got_q.size()) ? got_q[got_rd + i] : 'x;
            if (obs !== exp_q[i]) $display("FAIL skip_pix[%0d]: got %h, expected %h", i, obs, exp_q[i]);
            else passes++;
        end
        checks++;
        if (fs_cnt - fs0 != 2 || fd_cnt - fd0 != 2)
            $display("FAIL skip_pulses: got start=%0d done=%0d, expected 2 2", fs_cnt - fs0, fd_cnt - fd0);
        else passes++;
        frame_skip = '0;
    endtask

    task automatic test_back_to_back();
        int fd0;
        logic [EW-1:0] obs;
        cap_en = 1'b1;
        continuous = 1'b1;
        frame_skip = '0;
        do_reset();
        fd0 = fd_cnt;
        for (int f = 0; f < 3; f++) begin
            fill_frame(8, 8, 8, 3, 1'b0);
            model_frame(1, 0);
            drive_frame();
        end
        checks++;
        if (got_q.size() - got_rd != exp_q.size())
            $display("FAIL b2b_count: got %0d, expected %0d", got_q.size() - got_rd, exp_q.size());
        else passes++;
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            obs = (got_rd + i < got_q.size()) ? got_q[got_rd + i] : 'x;
            if (obs !== exp_q[i]) $display("FAIL b2b_pix[%0d]: got %h, expected %h", i, obs, exp_q[i]);
            else passes++;
        end
        checks++;
        if (fd_cnt - fd0 != 3 || state_dbg !== SYNC)
            $display("FAIL b2b_end: got done=%0d state=%0d, expected 3 %0d", fd_cnt - fd0, state_dbg, SYNC);
        else passes++;
    endtask

    task automatic test_reset_mid_frame();
        int fd0;
        logic [EW-1:0] obs;
        cap_en = 1'b1;
        continuous = 1'b1;
        do_reset();
        fill_frame(8, 8, 8, 3, 1'b0);
        frame_begin();
        drive_line(0, 0, 8);
        line_gap();
        drive_line(1, 0, 3);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++;
        if ({pix_data, pix_valid, pix_col, pix_row, frame_start, frame_done, busy,
             err_line, err_frame, err_overflow} !== '0)
            $display("FAIL midrst_outputs: got valid=%b data=%h busy=%b errs=%b, expected all 0",
                     pix_valid, pix_data, busy, {err_line, err_frame, err_overflow});
        else passes++;
        checks++;
        if (state_dbg !== IDLE) $display("FAIL midrst_state: got %0d, expected %0d", state_dbg, IDLE);
        else passes++;
        got_rd = got_q.size();
        fd0 = fd_cnt;
        drive_line(1, 3, 8);
        line_gap();
        drive_line(2, 0, 8);
        line_gap();
        frame_end();
        checks++;
        if (got_q.size() != got_rd || fd_cnt != fd0)
            $display("FAIL midrst_partial: got %0d pixels %0d done, expected 0 0", got_q.size() - got_rd, fd_cnt - fd0);
        else passes++;
        fill_frame(8, 8, 8, 3, 1'b0);
        model_frame(1, 0);
        drive_frame();
        checks++;
        if (got_q.size() - got_rd != exp_q.size())
            $display("FAIL midrst_count: got %0d, expected %0d", got_q.size() - got_rd, exp_q.size());
        else passes++;
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            obs = (got_rd + i < got_q.size()) ? got_q[got_rd + i] : 'x;
            if (obs !== exp_q[i]) $display("FAIL midrst_pix[%0d]: got %h, expected %h", i, obs, exp_q[i]);
            else passes++;
        end
    endtask

    task automatic test_cap_en_drop();
        int fd0, n0;
        logic [EW-1:0] obs;
        cap_en = 1'b1;
        continuous = 1'b1;
        do_reset();
        fd0 = fd_cnt;
        fill_frame(8, 8, 8, 3, 1'b0);
        model_frame(1, 0);
        frame_begin();
        drive_line(0, 0, 8);
        cap_en = 1'b0;
        line_gap();
        for (int r = 1; r < nlines; r++) begin
            drive_line(r, 0, flen[r]);
            line_gap();
        end
        frame_end();
        checks++;
        if (got_q.size() - got_rd != exp_q.size())
            $display("FAIL capdrop_count: got %0d, expected %0d", got_q.size() - got_rd, exp_q.size());
        else passes++;
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            obs = (got_rd + i < got_q.size()) ? got_q[got_rd + i] : 'x;
            if (obs !== exp_q[i]) $display("FAIL capdrop_pix[%0d]: got %h, expected %h", i, obs, exp_q[i]);
            else passes++;
        end
        checks++;
        if (fd_cnt - fd0 != 1 || state_at_done !== DONE)
            $display("FAIL capdrop_done: got done=%0d state=%0d, expected 1 %0d", fd_cnt - fd0, state_at_done, DONE);
        else passes++;
        n0 = got_q.size();
        fill_frame(8, 8, 8, 3, 1'b0);
        drive_frame();
        checks++;
        if (got_q.size() != n0 || state_dbg !== IDLE)
            $display("FAIL capdrop_after: got %0d pixels state=%0d, expected 0 %0d", got_q.size() - n0, state_dbg, IDLE);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_single_shot();
        test_back_pressure();
        test_short_line();
        test_frame_skip();
        test_back_to_back();
        test_reset_mid_frame();
        test_cap_en_drop();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
